// File: rtl/memory_module_pkg.sv
// Shared sizing for the matrix/filter register bank.
package memory_module_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int A_DIM      = 4;
  localparam int B_DIM      = 3;
  localparam int A_CNT      = A_DIM * A_DIM;
  localparam int B_CNT      = B_DIM * B_DIM;
endpackage

// File: rtl/mem_reg.sv
// Single DATA_W-bit storage register, async active-high clear.
// Latency: 1 clk. Backpressure: none, loads every edge.
module mem_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/memory_module.sv
// Registers a 4x4 matrix A and a 3x3 filter B position-for-position.
// Latency: 1 clk. Backpressure: none, every edge loads all 25 registers.
module memory_module
  import memory_module_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] A11, A12, A13, A14,
  input  logic [DATA_W-1:0] A21, A22, A23, A24,
  input  logic [DATA_W-1:0] A31, A32, A33, A34,
  input  logic [DATA_W-1:0] A41, A42, A43, A44,
  input  logic [DATA_W-1:0] B11, B12, B13,
  input  logic [DATA_W-1:0] B21, B22, B23,
  input  logic [DATA_W-1:0] B31, B32, B33,
  output logic [DATA_W-1:0] out_A11, out_A12, out_A13, out_A14,
  output logic [DATA_W-1:0] out_A21, out_A22, out_A23, out_A24,
  output logic [DATA_W-1:0] out_A31, out_A32, out_A33, out_A34,
  output logic [DATA_W-1:0] out_A41, out_A42, out_A43, out_A44,
  output logic [DATA_W-1:0] out_B11, out_B12, out_B13,
  output logic [DATA_W-1:0] out_B21, out_B22, out_B23,
  output logic [DATA_W-1:0] out_B31, out_B32, out_B33
);

  // Row-major flattening: index = (row-1)*DIM + (col-1)
  logic [DATA_W-1:0] a_d [A_CNT];
  logic [DATA_W-1:0] a_q [A_CNT];
  logic [DATA_W-1:0] b_d [B_CNT];
  logic [DATA_W-1:0] b_q [B_CNT];

  assign a_d[0]  = A11;
  assign a_d[1]  = A12;
  assign a_d[2]  = A13;
  assign a_d[3]  = A14;
  assign a_d[4]  = A21;
  assign a_d[5]  = A22;
  assign a_d[6]  = A23;
  assign a_d[7]  = A24;
  assign a_d[8]  = A31;
  assign a_d[9]  = A32;
  assign a_d[10] = A33;
  assign a_d[11] = A34;
  assign a_d[12] = A41;
  assign a_d[13] = A42;
  assign a_d[14] = A43;
  assign a_d[15] = A44;

  assign b_d[0] = B11;
  assign b_d[1] = B12;
  assign b_d[2] = B13;
  assign b_d[3] = B21;
  assign b_d[4] = B22;
  assign b_d[5] = B23;
  assign b_d[6] = B31;
  assign b_d[7] = B32;
  assign b_d[8] = B33;

  for (genvar i = 0; i < A_CNT; i++) begin : g_a
    mem_reg #(.DATA_W(DATA_W)) u_reg (.clk(clk), .rst(rst), .d(a_d[i]), .q(a_q[i]));
  end

  for (genvar i = 0; i < B_CNT; i++) begin : g_b
    mem_reg #(.DATA_W(DATA_W)) u_reg (.clk(clk), .rst(rst), .d(b_d[i]), .q(b_q[i]));
  end

  assign out_A11 = a_q[0];
  assign out_A12 = a_q[1];
  assign out_A13 = a_q[2];
  assign out_A14 = a_q[3];
  assign out_A21 = a_q[4];
  assign out_A22 = a_q[5];
  assign out_A23 = a_q[6];
  assign out_A24 = a_q[7];
  assign out_A31 = a_q[8];
  assign out_A32 = a_q[9];
  assign out_A33 = a_q[10];
  assign out_A34 = a_q[11];
  assign out_A41 = a_q[12];
  assign out_A42 = a_q[13];
  assign out_A43 = a_q[14];
  assign out_A44 = a_q[15];

  assign out_B11 = b_q[0];
  assign out_B12 = b_q[1];
  assign out_B13 = b_q[2];
  assign out_B21 = b_q[3];
  assign out_B22 = b_q[4];
  assign out_B23 = b_q[5];
  assign out_B31 = b_q[6];
  assign out_B32 = b_q[7];
  assign out_B33 = b_q[8];

endmodule

// File: tb/tb_memory_module.sv
// Randomised bench for memory_module against a "last sampled inputs" model.
module tb_memory_module;

  logic       clk;
  logic       rst;
  logic [7:0] a  [16];
  logic [7:0] b  [9];
  logic [7:0] oa [16];
  logic [7:0] ob [9];

  // Model: what each output should show now
  logic [7:0] exp_a [16];
  logic [7:0] exp_b [9];

  int tests_run;
  int tests_failed;

  memory_module #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .A11(a[0]),  .A12(a[1]),  .A13(a[2]),  .A14(a[3]),
    .A21(a[4]),  .A22(a[5]),  .A23(a[6]),  .A24(a[7]),
    .A31(a[8]),  .A32(a[9]),  .A33(a[10]), .A34(a[11]),
    .A41(a[12]), .A42(a[13]), .A43(a[14]), .A44(a[15]),
    .B11(b[0]), .B12(b[1]), .B13(b[2]),
    .B21(b[3]), .B22(b[4]), .B23(b[5]),
    .B31(b[6]), .B32(b[7]), .B33(b[8]),
    .out_A11(oa[0]),  .out_A12(oa[1]),  .out_A13(oa[2]),  .out_A14(oa[3]),
    .out_A21(oa[4]),  .out_A22(oa[5]),  .out_A23(oa[6]),  .out_A24(oa[7]),
    .out_A31(oa[8]),  .out_A32(oa[9]),  .out_A33(oa[10]), .out_A34(oa[11]),
    .out_A41(oa[12]), .out_A42(oa[13]), .out_A43(oa[14]), .out_A44(oa[15]),
    .out_B11(ob[0]), .out_B12(ob[1]), .out_B13(ob[2]),
    .out_B21(ob[3]), .out_B22(ob[4]), .out_B23(ob[5]),
    .out_B31(ob[6]), .out_B32(ob[7]), .out_B33(ob[8])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string phase);
    for (int i = 0; i < 16; i++)
      check_eq($sformatf("%s out_A%0d%0d", phase, i / 4 + 1, i % 4 + 1), oa[i], exp_a[i]);
    for (int i = 0; i < 9; i++)
      check_eq($sformatf("%s out_B%0d%0d", phase, i / 3 + 1, i % 3 + 1), ob[i], exp_b[i]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) exp_a[i] = 8'd0;
    for (int i = 0; i < 9; i++)  exp_b[i] = 8'd0;
  endtask

  // One rising edge: model captures inputs unless reset holds, then settle 1ns
  task automatic tick();
    @(posedge clk);
    if (rst) clear_model();
    else begin
      for (int i = 0; i < 16; i++) exp_a[i] = a[i];
      for (int i = 0; i < 9; i++)  exp_b[i] = b[i];
    end
    #1;
  endtask

  task automatic set_seq(input int a_base, input int b_base);
    for (int i = 0; i < 16; i++) a[i] = 8'(a_base + i);
    for (int i = 0; i < 9; i++)  b[i] = 8'(b_base + i);
  endtask

  // mode 0: random with sprinkled 0x00/0xFF, 1: all 0x00, 2: all 0xFF
  task automatic set_rand(input int mode);
    for (int i = 0; i < 25; i++) begin
      logic [7:0] v;
      case (mode)
        1:       v = 8'h00;
        2:       v = 8'hFF;
        default: begin
          case ($urandom_range(0, 7))
            0:       v = 8'h00;
            1:       v = 8'hFF;
            default: v = 8'($urandom);
          endcase
        end
      endcase
      if (i < 16) a[i] = v;
      else        b[i - 16] = v;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    set_rand(0);
    clear_model();
    #2;
    check_all("reset");
    for (int k = 0; k < 3; k++) begin
      set_rand(0);
      tick();
      check_all("reset_hold");
    end

    // Known pattern, held for 5 edges
    #3;
    rst = 1'b0;
    set_seq(1, 17);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_all("pattern");
    end
    check_eq("pattern out_A11", oa[0], 8'd1);
    check_eq("pattern out_A44", oa[15], 8'd16);
    check_eq("pattern out_B11", ob[0], 8'd17);
    check_eq("pattern out_B33", ob[8], 8'd25);

    // Reset raised between edges clears immediately
    #3;
    rst = 1'b1;
    clear_model();
    #1;
    check_all("async_rst");
    for (int k = 0; k < 5; k++) begin
      set_rand(0);
      tick();
      check_all("rst_toggle");
    end

    // Release: outputs stay 0 until the first edge
    #3;
    rst = 1'b0;
    set_seq(101, 117);
    #1;
    check_all("post_rst_pre_edge");
    tick();
    check_all("post_rst_edge");
    check_eq("post_rst out_A11", oa[0], 8'd101);
    check_eq("post_rst out_A44", oa[15], 8'd116);
    check_eq("post_rst out_B33", ob[8], 8'd125);

    // Mid-cycle change of A23 must wait for the edge
    a[6] = 8'd7;
    tick();
    check_eq("a23 before", oa[6], 8'd7);
    #3;
    a[6] = 8'd200;
    #1;
    check_eq("a23 mid_cycle", oa[6], 8'd7);
    check_all("a23 mid_cycle");
    tick();
    check_eq("a23 after", oa[6], 8'd200);
    check_all("a23 after");

    // Random per-edge traffic with boundary sweeps
    for (int k = 0; k < 100; k++) begin
      if (k % 10 == 3)      set_rand(1);
      else if (k % 10 == 7) set_rand(2);
      else                  set_rand(0);
      #2;
      check_all("rand_mid");
      tick();
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
